// File: rtl/reload_counter_ctrl.sv
// Command-driven controller for a reloadable up counter: LOAD/START/STOP/CLEAR over
// a valid/ready handshake, terminal-count detection, auto-reload and event tally.
module reload_counter_ctrl #(
  parameter int unsigned           WIDTH    = 8,
  parameter logic [WIDTH-1:0]      TERMINAL = '1
) (
  input  logic             CLK,
  input  logic             RESET_BTN,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CE,
  input  logic             AUTO_RELOAD,
  output logic [WIDTH-1:0] COUNT,
  output logic [1:0]       STATE,
  output logic             BUSY,
  output logic             TC_PULSE,
  output logic [7:0]       TC_EVENTS
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_ready;
  logic             r_tc;
  logic [7:0]       r_events;

  op_t  w_op;
  logic w_accept;
  logic w_step;
  logic w_load;

  assign w_op     = op_t'(CMD_OP);
  assign w_accept = CMD_VALID & r_ready;
  assign w_load   = w_accept & (w_op == OP_LOAD);
  // STOP and CLEAR both have op[1] set; either one pre-empts the RUN step.
  assign w_step   = (r_state == S_RUN) & CE & ~(w_accept & CMD_OP[1]);

  always_ff @(posedge CLK or negedge RESET_BTN) begin
    if (!RESET_BTN) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_ready  <= 1'b1;
      r_tc     <= 1'b0;
      r_events <= '0;
    end else begin
      r_ready <= ~w_accept;
      r_tc    <= 1'b0;

      if (w_step) begin
        if (r_count == TERMINAL) begin
          r_tc <= 1'b1;
          if (r_events != 8'hFF) r_events <= r_events + 8'd1;
          if (AUTO_RELOAD) r_count <= w_load ? CMD_DATA : r_reload;
          else             r_state <= S_DONE;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end

      // Command effects are applied after the step so they take priority where they overlap.
      if (w_accept) begin
        unique case (w_op)
          OP_LOAD: begin
            r_reload <= CMD_DATA;
            if (r_state != S_RUN) r_count <= CMD_DATA;
          end
          OP_START: begin
            if (r_state == S_DONE) begin
              r_state <= S_RUN;
              r_count <= r_reload;
            end else if (r_state != S_RUN) begin
              r_state <= S_RUN;
            end
          end
          OP_STOP: begin
            if (r_state == S_RUN) r_state <= S_PAUSED;
          end
          OP_CLEAR: begin
            r_state  <= S_IDLE;
            r_count  <= r_reload;
            r_events <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign CMD_READY = r_ready;
  assign COUNT     = r_count;
  assign STATE     = r_state;
  assign BUSY      = (r_state == S_RUN);
  assign TC_PULSE  = r_tc;
  assign TC_EVENTS = r_events;

endmodule

// File: tb/tb_reload_counter_ctrl.sv
// Directed bench: vector table on a TERMINAL=FF instance plus hand sequences for
// auto-reload, pause, coincident commands and async reset (second instance TERMINAL=10).
module tb_reload_counter_ctrl;

  localparam logic [1:0] L = 2'd0, S = 2'd1, P = 2'd2, C = 2'd3;
  localparam logic [1:0] ST_I = 2'd0, ST_R = 2'd1, ST_P = 2'd2, ST_D = 2'd3;

  logic       CLK, RESET_BTN, CMD_VALID, CE, AUTO_RELOAD;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_DATA;

  logic       rdy_a, busy_a, tc_a, rdy_b, busy_b, tc_b;
  logic [7:0] cnt_a, ev_a, cnt_b, ev_b;
  logic [1:0] st_a, st_b;

  int n_vec = 0;
  int n_err = 0;

  reload_counter_ctrl #(.WIDTH(8), .TERMINAL(8'hFF)) dut_a (
    .CLK(CLK), .RESET_BTN(RESET_BTN), .CMD_VALID(CMD_VALID), .CMD_READY(rdy_a),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CE(CE), .AUTO_RELOAD(AUTO_RELOAD),
    .COUNT(cnt_a), .STATE(st_a), .BUSY(busy_a), .TC_PULSE(tc_a), .TC_EVENTS(ev_a));

  reload_counter_ctrl #(.WIDTH(8), .TERMINAL(8'h10)) dut_b (
    .CLK(CLK), .RESET_BTN(RESET_BTN), .CMD_VALID(CMD_VALID), .CMD_READY(rdy_b),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CE(CE), .AUTO_RELOAD(AUTO_RELOAD),
    .COUNT(cnt_b), .STATE(st_b), .BUSY(busy_b), .TC_PULSE(tc_b), .TC_EVENTS(ev_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] d;
    logic       ce;
    logic       ar;
    logic [7:0] cnt;
    logic [1:0] st;
    logic       rdy;
    logic       tc;
    logic [7:0] ev;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Packed fields: {count, state, ready, tc_pulse, tc_events, busy}
  task automatic cmp(input string nm, input logic [20:0] act, input logic [7:0] c,
                     input logic [1:0] s, input logic r, input logic t, input logic [7:0] e);
    logic [20:0] exp;
    exp = {c, s, r, t, e, (s == ST_R)};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {count,state,ready,tc,events,busy} got cnt=%h st=%0d rdy=%b tc=%b ev=%h busy=%b, want cnt=%h st=%0d rdy=%b tc=%b ev=%h busy=%b",
               nm, act[20:13], act[12:11], act[10], act[9], act[8:1], act[0],
               c, s, r, t, e, (s == ST_R));
    end
  endtask

  task automatic chk_a(input string nm, input logic [7:0] c, input logic [1:0] s,
                       input logic r, input logic t, input logic [7:0] e);
    cmp(nm, {cnt_a, st_a, rdy_a, tc_a, ev_a, busy_a}, c, s, r, t, e);
  endtask

  task automatic chk_b(input string nm, input logic [7:0] c, input logic [1:0] s,
                       input logic r, input logic t, input logic [7:0] e);
    cmp(nm, {cnt_b, st_b, rdy_b, tc_b, ev_b, busy_b}, c, s, r, t, e);
  endtask

  task automatic do_reset();
    CMD_VALID = 1'b0;
    CE        = 1'b0;
    #2 RESET_BTN = 1'b0;
    @(negedge CLK);
    RESET_BTN = 1'b1;
    step();
  endtask

  // Idle-state command followed by the mandatory ready-recovery cycle.
  task automatic idle_cmd(input logic [1:0] op, input logic [7:0] d);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = d;
    step();
    CMD_VALID = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] mc, mev;
    logic       mtc;

    CMD_VALID = 1'b0; CMD_OP = L; CMD_DATA = '0; CE = 1'b0; AUTO_RELOAD = 1'b0;
    RESET_BTN = 1'b0;

    //             v  op d      ce ar  cnt    st    rdy tc ev
    tbl.push_back('{1, L, 8'h05, 0, 0, 8'h05, ST_I, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 0, 0, 8'h05, ST_I, 1, 0, 8'd0});
    tbl.push_back('{1, S, 8'h00, 0, 0, 8'h05, ST_R, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'h06, ST_R, 1, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 0, 0, 8'h06, ST_R, 1, 0, 8'd0});
    tbl.push_back('{1, P, 8'h00, 1, 0, 8'h06, ST_P, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'h06, ST_P, 1, 0, 8'd0});
    tbl.push_back('{1, L, 8'hFD, 1, 0, 8'hFD, ST_P, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFD, ST_P, 1, 0, 8'd0});
    tbl.push_back('{1, S, 8'h00, 1, 0, 8'hFD, ST_R, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFE, ST_R, 1, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFF, ST_R, 1, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFF, ST_D, 1, 1, 8'd1});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFF, ST_D, 1, 0, 8'd1});
    tbl.push_back('{1, S, 8'h00, 1, 0, 8'hFD, ST_R, 0, 0, 8'd1});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFE, ST_R, 1, 0, 8'd1});
    tbl.push_back('{1, C, 8'h00, 1, 0, 8'hFD, ST_I, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 0, 8'hFD, ST_I, 1, 0, 8'd0});
    tbl.push_back('{1, S, 8'h00, 1, 0, 8'hFD, ST_R, 0, 0, 8'd0});
    tbl.push_back('{1, L, 8'h10, 1, 0, 8'hFE, ST_R, 1, 0, 8'd0});
    tbl.push_back('{1, L, 8'h10, 1, 0, 8'hFF, ST_R, 0, 0, 8'd0});
    tbl.push_back('{0, L, 8'h00, 1, 1, 8'h10, ST_R, 1, 1, 8'd1});
    tbl.push_back('{1, S, 8'h00, 1, 1, 8'h11, ST_R, 0, 0, 8'd1});
    tbl.push_back('{0, L, 8'h00, 1, 1, 8'h12, ST_R, 1, 0, 8'd1});
    tbl.push_back('{1, P, 8'h00, 1, 1, 8'h12, ST_P, 0, 0, 8'd1});
    tbl.push_back('{0, L, 8'h00, 1, 1, 8'h12, ST_P, 1, 0, 8'd1});

    repeat (2) @(negedge CLK);
    RESET_BTN = 1'b1;
    chk_a("reset_a", 8'h00, ST_I, 1, 0, 8'd0);
    chk_b("reset_b", 8'h00, ST_I, 1, 0, 8'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      CMD_VALID = tbl[i].v; CMD_OP = tbl[i].op; CMD_DATA = tbl[i].d;
      CE = tbl[i].ce; AUTO_RELOAD = tbl[i].ar;
      step();
      chk_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].st, tbl[i].rdy, tbl[i].tc, tbl[i].ev);
    end

    // Full run 05..FF then DONE with a single terminal event.
    do_reset();
    AUTO_RELOAD = 1'b0;
    idle_cmd(L, 8'h05);
    CMD_VALID = 1'b1; CMD_OP = S; CE = 1'b1;
    step();
    CMD_VALID = 1'b0;
    chk_a("full_start", 8'h05, ST_R, 0, 0, 8'd0);
    for (int i = 1; i <= 250; i++) begin
      step();
      chk_a($sformatf("full_inc%0d", i), 8'(5 + i), ST_R, 1, 0, 8'd0);
    end
    step();
    chk_a("full_done", 8'hFF, ST_D, 1, 1, 8'd1);
    step();
    chk_a("full_hold", 8'hFF, ST_D, 1, 0, 8'd1);

    // Auto-reload with TERMINAL=10: period-3 pulses, event tally saturates.
    do_reset();
    AUTO_RELOAD = 1'b1;
    idle_cmd(L, 8'h0E);
    CMD_VALID = 1'b1; CMD_OP = S; CE = 1'b1;
    step();
    CMD_VALID = 1'b0;
    chk_b("ar_start", 8'h0E, ST_R, 0, 0, 8'd0);
    mc = 8'h0E; mev = 8'd0;
    for (int i = 0; i < 780; i++) begin
      step();
      if (mc == 8'h10) begin
        mc = 8'h0E; mtc = 1'b1;
        if (mev != 8'hFF) mev = mev + 8'd1;
      end else begin
        mc = mc + 8'd1; mtc = 1'b0;
      end
      chk_b($sformatf("ar_cyc%0d", i), mc, ST_R, 1, mtc, mev);
    end
    chk_b("ar_saturated", mc, ST_R, 1, mtc, 8'hFF);

    // Pause at 40 with CE toggling, then resume.
    do_reset();
    AUTO_RELOAD = 1'b0;
    idle_cmd(L, 8'h3E);
    CMD_VALID = 1'b1; CMD_OP = S; CE = 1'b1;
    step();
    CMD_VALID = 1'b0;
    step();
    step();
    chk_a("pause_at40", 8'h40, ST_R, 1, 0, 8'd0);
    CMD_VALID = 1'b1; CMD_OP = P;
    step();
    CMD_VALID = 1'b0;
    chk_a("pause_stop", 8'h40, ST_P, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      CE = i[0];
      step();
      chk_a($sformatf("pause_hold%0d", i), 8'h40, ST_P, 1, 0, 8'd0);
    end
    CE = 1'b1; CMD_VALID = 1'b1; CMD_OP = S;
    step();
    CMD_VALID = 1'b0;
    chk_a("pause_restart", 8'h40, ST_R, 0, 0, 8'd0);
    step();
    chk_a("pause_resume", 8'h41, ST_R, 1, 0, 8'd0);

    // LOAD on an auto-reload terminal edge, then a CLEAR held through the not-ready cycle.
    do_reset();
    AUTO_RELOAD = 1'b1;
    idle_cmd(L, 8'h0E);
    CMD_VALID = 1'b1; CMD_OP = S; CE = 1'b1;
    step();
    CMD_VALID = 1'b0;
    step();
    step();
    chk_b("fwd_at10", 8'h10, ST_R, 1, 0, 8'd0);
    CMD_VALID = 1'b1; CMD_OP = L; CMD_DATA = 8'h20;
    step();
    chk_b("fwd_load", 8'h20, ST_R, 0, 1, 8'd1);
    CMD_OP = C; CMD_DATA = 8'h00;
    step();
    chk_b("fwd_notready", 8'h21, ST_R, 1, 0, 8'd1);
    step();
    CMD_VALID = 1'b0;
    chk_b("fwd_clear", 8'h20, ST_I, 0, 0, 8'd0);

    // CLEAR on a terminal edge suppresses the event.
    do_reset();
    AUTO_RELOAD = 1'b1;
    idle_cmd(L, 8'h0E);
    CMD_VALID = 1'b1; CMD_OP = S; CE = 1'b1;
    step();
    CMD_VALID = 1'b0;
    step(); step(); step();
    chk_b("clr_first_evt", 8'h0E, ST_R, 1, 1, 8'd1);
    step(); step();
    chk_b("clr_at10", 8'h10, ST_R, 1, 0, 8'd1);
    CMD_VALID = 1'b1; CMD_OP = C;
    step();
    CMD_VALID = 1'b0;
    chk_b("clr_terminal", 8'h0E, ST_I, 0, 0, 8'd0);
    step();
    chk_b("clr_after", 8'h0E, ST_I, 1, 0, 8'd0);

    // Asynchronous reset mid-RUN at 77.
    do_reset();
    AUTO_RELOAD = 1'b0;
    idle_cmd(L, 8'h77);
    CMD_VALID = 1'b1; CMD_OP = S; CE = 1'b0;
    step();
    CMD_VALID = 1'b0;
    step();
    chk_a("rst_run77", 8'h77, ST_R, 1, 0, 8'd0);
    #2 RESET_BTN = 1'b0;
    #1 chk_a("rst_async", 8'h00, ST_I, 1, 0, 8'd0);
    @(negedge CLK);
    RESET_BTN = 1'b1;
    CE = 1'b1;
    step(); step(); step();
    chk_a("rst_after", 8'h00, ST_I, 1, 0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
